// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter and sequences instruction fetches
// for the single-cycle core. At most one memory access is outstanding. The
// returned word is held for decode. Redirects from branch/jump resolution
// retarget the PC. Responses that belong to wrong-path fetches are dropped.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/imem_addr  fetch request and its word-aligned address
//   imem_gnt            request accepted this cycle
//   imem_rvalid/rdata   returned instruction word
//   if_valid/instr/pc   held instruction presented to decode
//   if_ready            decode accepts the held instruction
//   redirect/_pc        taken branch/jump and its target (bits [1:0] ignored)
//   fetch_count         instructions delivered to decode (wraps)
`timescale 1ns/1ps
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   ipc_q, ipc_d;
  logic [XLEN-1:0]   count_q, count_d;
  logic              req_q;
  logic              valid_q;
  logic [XLEN-1:0]   redir_tgt;

  // Redirect target forced to word alignment.
  assign redir_tgt = redirect_pc & ~XLEN'(3);

  // State and datapath registers; request/valid flags are registered copies
  // of the next-state decode so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      count_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      count_q <= count_d;
      req_q   <= (state_d == ST_REQ);
      valid_q <= (state_d == ST_HOLD);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    count_d = count_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redirect) begin
          pc_d = redir_tgt;
        end
        // A grant alongside a redirect is for the old pc: its data is stale.
        if (imem_gnt) begin
          state_d = ST_WAIT;
          kill_d  = redirect;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          kill_d = 1'b0;
          if (kill_q || redirect) begin
            state_d = ST_REQ;
            if (redirect) begin
              pc_d = redir_tgt;
            end
          end else begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            pc_d    = pc_q + XLEN'(4);
            state_d = ST_HOLD;
          end
        end else if (redirect) begin
          // Response still owed: mark it stale and wait it out.
          kill_d = 1'b1;
          pc_d   = redir_tgt;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d    = redir_tgt;
          state_d = ST_REQ;
        end else if (if_ready) begin
          count_d = count_q + XLEN'(1);
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ipc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (RESET_PC 0 and 32'hFFFF_FFFC)
// share every input. A cycle-stepped memory model answers requests; expected
// deliveries are queued per instance and a negedge monitor checks them.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gnt, rvalid, ready, redirect;
  logic [31:0] rdata, redirect_pc;

  logic        imem_req_a, if_valid_a, imem_req_b, if_valid_b;
  logic [31:0] imem_addr_a, if_instr_a, if_pc_a, fetch_count_a;
  logic [31:0] imem_addr_b, if_instr_b, if_pc_b, fetch_count_b;

  exp_t exp_a[$];
  exp_t exp_b[$];

  int total = 0;
  int bad   = 0;

  // memory model state
  logic        pend = 1'b0;
  int          delay = 0;
  int          mem_lat = 1;
  logic [31:0] paddr = '0;

  always #5 clk = ~clk;

  fetch_sequencer u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req_a), .imem_addr(imem_addr_a), .imem_gnt(gnt),
    .imem_rvalid(rvalid), .imem_rdata(rdata),
    .if_valid(if_valid_a), .if_instr(if_instr_a), .if_pc(if_pc_a),
    .if_ready(ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_count(fetch_count_a)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_gnt(gnt),
    .imem_rvalid(rvalid), .imem_rdata(rdata),
    .if_valid(if_valid_b), .if_instr(if_instr_b), .if_pc(if_pc_b),
    .if_ready(ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_count(fetch_count_b)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pa, input logic [31:0] pb, input logic [31:0] ins);
    exp_t e;
    e.instr = ins;
    e.pc = pa; exp_a.push_back(e);
    e.pc = pb; exp_b.push_back(e);
  endtask

  // One cycle: drive inputs just after the edge; memory grants every request
  // (address taken from instance A) and answers mem_lat cycles later.
  task automatic step(input logic rd, input logic [31:0] rp, input logic rdy);
    @(posedge clk); #1;
    gnt    = 1'b0;
    rvalid = 1'b0;
    if (pend) begin
      delay--;
      if (delay == 0) begin
        rvalid = 1'b1;
        rdata  = memf(paddr);
        pend   = 1'b0;
      end
    end
    if (!pend && !rvalid && imem_req_a) begin
      gnt   = 1'b1;
      pend  = 1'b1;
      paddr = imem_addr_a;
      delay = mem_lat;
    end
    redirect    = rd;
    redirect_pc = rp;
    ready       = rdy;
  endtask

  // Scoreboard monitor: every completed transfer pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && if_valid_a && ready && !redirect) begin
      if (exp_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected pc=%h", if_pc_a);
      end else begin
        e = exp_a.pop_front();
        chk("a_pc", if_pc_a, e.pc);
        chk("a_instr", if_instr_a, e.instr);
      end
    end
    if (rst_n && if_valid_b && ready && !redirect) begin
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected pc=%h", if_pc_b);
      end else begin
        e = exp_b.pop_front();
        chk("b_pc", if_pc_b, e.pc);
        chk("b_instr", if_instr_b, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req_a), 32'd0);
    chk("rst_valid", 32'(if_valid_a), 32'd0);
    chk("rst_count", fetch_count_a, 32'd0);
    chk("rst_addr_a", imem_addr_a, 32'h0);
    chk("rst_addr_b", imem_addr_b, 32'hFFFF_FFFC);
    chk("rst_ifpc", if_pc_a, 32'h0);
    chk("rst_instr", if_instr_a, 32'h0);
    chk("rst_req_b", 32'(imem_req_b), 32'd0);
    rst_n = 1'b1;

    // Sequential fetch, zero-wait memory, decode always ready (steps 1-9).
    push(32'h0, 32'hFFFF_FFFC, memf(32'h0));
    push(32'h4, 32'h0,         memf(32'h4));
    push(32'h8, 32'h4,         memf(32'h8));
    repeat (9) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);                      // step 10: REQ
    chk("seq_count_a", fetch_count_a, 32'd3);
    chk("seq_count_b", fetch_count_b, 32'd3);
    chk("seq_req", 32'(imem_req_a), 32'd1);
    chk("seq_addr", imem_addr_a, 32'hC);
    step(1'b0, '0, 1'b1);                      // step 11: WAIT

    // Backpressure: five HOLD cycles with decode stalled.
    push(32'hC, 32'h8, memf(32'hC));
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0);
      chk("bp_valid", 32'(if_valid_a), 32'd1);
      chk("bp_pc", if_pc_a, 32'hC);
      chk("bp_instr", if_instr_a, memf(32'hC));
      chk("bp_req", 32'(imem_req_a), 32'd0);
      chk("bp_count", fetch_count_a, 32'd3);
      chk("bp_pc_b", if_pc_b, 32'h8);
    end
    step(1'b0, '0, 1'b1);                      // step 17: delivered

    // Redirect while waiting; stale response arrives 2 cycles later.
    mem_lat = 3;
    step(1'b0, '0, 1'b1);                      // step 18: grant pc 0x10
    mem_lat = 1;
    step(1'b1, 32'h100, 1'b1);                 // step 19: WAIT + redirect
    step(1'b0, '0, 1'b1);                      // step 20
    step(1'b0, '0, 1'b1);                      // step 21: stale rvalid
    step(1'b0, '0, 1'b1);                      // step 22
    chk("wr_addr_a", imem_addr_a, 32'h100);
    chk("wr_addr_b", imem_addr_b, 32'h100);
    chk("wr_req", 32'(imem_req_a), 32'd1);
    push(32'h100, 32'h100, memf(32'h100));
    step(1'b0, '0, 1'b1);                      // step 23
    step(1'b0, '0, 1'b1);                      // step 24: delivered

    // Redirect coincident with grant.
    step(1'b1, 32'h200, 1'b1);                 // step 25
    step(1'b0, '0, 1'b1);                      // step 26: dropped
    step(1'b0, '0, 1'b1);                      // step 27
    chk("gr_addr", imem_addr_a, 32'h200);
    chk("gr_req", 32'(imem_req_a), 32'd1);
    step(1'b0, '0, 1'b1);                      // step 28

    // Redirect in HOLD with decode ready: held word is discarded.
    step(1'b1, 32'h301, 1'b1);                 // step 29
    step(1'b0, '0, 1'b1);                      // step 30
    chk("hr_addr", imem_addr_a, 32'h300);
    chk("hr_count_a", fetch_count_a, 32'd5);
    chk("hr_count_b", fetch_count_b, 32'd5);
    push(32'h300, 32'h300, memf(32'h300));
    step(1'b0, '0, 1'b1);                      // step 31
    step(1'b0, '0, 1'b1);                      // step 32: delivered
    mem_lat = 3;
    step(1'b0, '0, 1'b1);                      // step 33: grant pc 0x304
    mem_lat = 1;
    chk("hr_count2", fetch_count_a, 32'd6);

    // Reset pulse during WAIT; the late response must be ignored.
    step(1'b0, '0, 1'b1);                      // step 34: WAIT
    rst_n = 1'b0;
    #1;
    chk("mr_req", 32'(imem_req_a), 32'd0);
    chk("mr_valid", 32'(if_valid_a), 32'd0);
    chk("mr_count", fetch_count_a, 32'd0);
    chk("mr_addr_a", imem_addr_a, 32'h0);
    chk("mr_addr_b", imem_addr_b, 32'hFFFF_FFFC);
    step(1'b0, '0, 1'b1);                      // step 35
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1);                      // step 36: late rvalid in REQ
    chk("lr_rvalid", 32'(rvalid), 32'd1);
    chk("lr_req", 32'(imem_req_a), 32'd1);
    chk("lr_addr_a", imem_addr_a, 32'h0);
    chk("lr_addr_b", imem_addr_b, 32'hFFFF_FFFC);
    push(32'h0, 32'hFFFF_FFFC, memf(32'h0));
    step(1'b0, '0, 1'b1);                      // step 37: grant
    step(1'b0, '0, 1'b1);                      // step 38
    step(1'b0, '0, 1'b1);                      // step 39: delivered
    step(1'b0, '0, 1'b1);                      // step 40
    chk("end_count_a", fetch_count_a, 32'd1);
    chk("end_addr_a", imem_addr_a, 32'h4);
    chk("end_addr_b", imem_addr_b, 32'h0);
    chk("end_q_a", 32'(exp_a.size()), 32'd0);
    chk("end_q_b", 32'(exp_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
